// File: rtl/pedagio_pkg.sv
// Shared definitions for the toll-lane vehicle-record link: FSM states,
// axle category codes and rejection causes, also decoded by the accumulator.
package pedagio_pkg;

    typedef enum logic [2:0] {IDLE, MEASURE, SETUP, REPORT, GAP} state_t;

    localparam logic [1:0] EIXOS_2       = 2'b00;
    localparam logic [1:0] EIXOS_3       = 2'b01;
    localparam logic [1:0] EIXOS_4       = 2'b10;
    localparam logic [1:0] EIXOS_5P      = 2'b11;

    localparam logic [1:0] ERR_FEW_AXLES = 2'b01;
    localparam logic [1:0] ERR_NO_WEIGHT = 2'b10;

    // Category for an accepted vehicle; only called with two or more axles.
    function automatic logic [1:0] axle_code(input logic [2:0] axles);
        case (axles)
            3'd2:    axle_code = EIXOS_2;
            3'd3:    axle_code = EIXOS_3;
            3'd4:    axle_code = EIXOS_4;
            default: axle_code = EIXOS_5P;
        endcase
    endfunction

endpackage

// File: rtl/pedagio_sensor_frontend_if.sv
// Vehicle-record bus from the lane front end to the toll accumulator.
interface pedagio_sensor_frontend_if;
    import pedagio_pkg::*;

    logic [1:0] EIXOS;
    logic [3:0] PESO;
    logic       READY;

    modport master (output EIXOS, PESO, READY);
    modport slave  (input  EIXOS, PESO, READY);
endinterface

// File: rtl/pedagio_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for a bouncy
// contact; emits the filtered level and a one-cycle pulse on its rising edge.
module pedagio_debounce
    import pedagio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pedagio_sensor_frontend.sv
// Lane front end: conditions presence/axle/scale inputs, measures one vehicle
// and reports it as an EIXOS/PESO record with a READY level pulse.
module pedagio_sensor_frontend
    import pedagio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned PRES_OFF_CYC = 2500000,
    parameter int unsigned READY_HOLD   = 5000000,
    parameter int unsigned GAP_CYC      = 5000000
) (
    input  logic                             CLOCK_50,
    input  logic                             RESET,
    input  logic                             PRESENCE,
    input  logic                             AXLE_SENSOR,
    input  logic                             WEIGHT_STB,
    input  logic [3:0]                       WEIGHT_IN,
    pedagio_sensor_frontend_if.master        rec,
    output logic                             BUSY,
    output logic                             ERR,
    output logic [1:0]                       ERR_CODE
);
    localparam int unsigned P_MAX1 = (PRES_OFF_CYC > READY_HOLD) ? PRES_OFF_CYC : READY_HOLD;
    localparam int unsigned P_MAX  = (P_MAX1 > GAP_CYC) ? P_MAX1 : GAP_CYC;
    localparam int CW = $clog2(P_MAX) + 1;
    localparam logic [CW-1:0] OFF_LAST  = CW'(PRES_OFF_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(READY_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    state_t        state;
    logic          pres_s1;
    logic          pres_s2;
    logic [CW-1:0] cnt;
    logic [2:0]    axles;
    logic [2:0]    axles_n;
    logic [3:0]    max_w;
    logic [3:0]    max_w_n;
    logic          seen;
    logic          seen_n;
    logic          axle_level;
    logic          axle_rise;

    pedagio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_axle (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .raw   (AXLE_SENSOR),
        .level (axle_level),
        .rise  (axle_rise)
    );

    // Same-cycle axle edges and weight strobes feed the evaluation directly.
    always_comb begin
        axles_n = axles;
        if (axle_rise && axle_level && axles != 3'd7)
            axles_n = axles + 3'd1;
        max_w_n = max_w;
        seen_n  = seen;
        if (WEIGHT_STB) begin
            seen_n = 1'b1;
            if (WEIGHT_IN > max_w)
                max_w_n = WEIGHT_IN;
        end
    end

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= IDLE;
            pres_s1   <= 1'b0;
            pres_s2   <= 1'b0;
            cnt       <= '0;
            axles     <= 3'd0;
            max_w     <= 4'd0;
            seen      <= 1'b0;
            rec.EIXOS <= 2'b00;
            rec.PESO  <= 4'd0;
            rec.READY <= 1'b0;
            ERR       <= 1'b0;
            ERR_CODE  <= 2'b00;
        end else begin
            pres_s1 <= PRESENCE;
            pres_s2 <= pres_s1;
            ERR     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pres_s2) begin
                        state <= MEASURE;
                        cnt   <= '0;
                        axles <= 3'd0;
                        max_w <= 4'd0;
                        seen  <= 1'b0;
                    end
                end
                MEASURE: begin
                    axles <= axles_n;
                    max_w <= max_w_n;
                    seen  <= seen_n;
                    if (pres_s2) begin
                        cnt <= '0;
                    end else if (cnt == OFF_LAST) begin
                        cnt <= '0;
                        if (axles_n < 3'd2 || !seen_n) begin
                            ERR      <= 1'b1;
                            ERR_CODE <= ((axles_n < 3'd2) ? ERR_FEW_AXLES : 2'b00)
                                      | (seen_n ? 2'b00 : ERR_NO_WEIGHT);
                            state    <= IDLE;
                        end else begin
                            // Data lands one cycle ahead of READY so it is stable at the edge.
                            rec.EIXOS <= axle_code(axles_n);
                            rec.PESO  <= max_w_n;
                            state     <= SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETUP: begin
                    rec.READY <= 1'b1;
                    cnt       <= '0;
                    state     <= REPORT;
                end
                REPORT: begin
                    if (cnt == HOLD_LAST) begin
                        rec.READY <= 1'b0;
                        cnt       <= '0;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pedagio_sensor_frontend.sv
// Scoreboard bench for the lane front end: stimulus pushes expected records or
// rejections, a monitor pops and compares them as READY rises or ERR pulses.
module tb_pedagio_sensor_frontend;
    import pedagio_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       PRESENCE;
    logic       AXLE_SENSOR;
    logic       WEIGHT_STB;
    logic [3:0] WEIGHT_IN;
    logic       BUSY;
    logic       ERR;
    logic [1:0] ERR_CODE;

    pedagio_sensor_frontend_if rec ();

    pedagio_sensor_frontend #(
        .DEBOUNCE_CYC (4),
        .PRES_OFF_CYC (8),
        .READY_HOLD   (6),
        .GAP_CYC      (4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .PRESENCE    (PRESENCE),
        .AXLE_SENSOR (AXLE_SENSOR),
        .WEIGHT_STB  (WEIGHT_STB),
        .WEIGHT_IN   (WEIGHT_IN),
        .rec         (rec.master),
        .BUSY        (BUSY),
        .ERR         (ERR),
        .ERR_CODE    (ERR_CODE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       is_err;
        logic [1:0] eixos;
        logic [3:0] peso;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_rec(input logic [1:0] e, input logic [3:0] p);
        exp_q.push_back('{is_err: 1'b0, eixos: e, peso: p, code: 2'b00});
    endtask

    task automatic push_err(input logic [1:0] c, input logic [1:0] e, input logic [3:0] p);
        exp_q.push_back('{is_err: 1'b1, eixos: e, peso: p, code: c});
    endtask

    task automatic strobe(input int w);
        if (w >= 0) begin
            WEIGHT_STB = 1'b1;
            WEIGHT_IN  = 4'(w);
            @(negedge CLOCK_50);
            WEIGHT_STB = 1'b0;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic vehicle(input int axles, input bit bounce, input int drop_after,
                           input int w0, input int w1, input int w2);
        @(negedge CLOCK_50);
        PRESENCE = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        for (int a = 0; a < axles; a++) begin
            if (bounce) begin
                AXLE_SENSOR = 1'b1;
                repeat (2) @(negedge CLOCK_50);
                AXLE_SENSOR = 1'b0;
                repeat (3) @(negedge CLOCK_50);
            end
            AXLE_SENSOR = 1'b1;
            repeat (10) @(negedge CLOCK_50);
            AXLE_SENSOR = 1'b0;
            repeat (10) @(negedge CLOCK_50);
            if (a == drop_after) begin
                PRESENCE = 1'b0;
                repeat (5) @(negedge CLOCK_50);
                PRESENCE = 1'b1;
                repeat (4) @(negedge CLOCK_50);
            end
        end
        strobe(w0);
        strobe(w1);
        strobe(w2);
        PRESENCE = 1'b0;
    endtask

    // Monitor: sample one time unit after each active edge.
    logic       prev_ready = 1'b0;
    logic       prev_err   = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [1:0] prev_eixos = 2'b00;
    logic [3:0] prev_peso  = 4'd0;
    int         ready_len  = 0;
    int         gap_len    = 0;
    bit         gap_on     = 1'b0;

    initial begin : monitor
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (mon_en) begin
                if (rec.READY && !prev_ready) begin
                    ready_len = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got record %0d/%0d, expected none", rec.EIXOS, rec.PESO);
                    end else begin
                        cur = exp_q.pop_front();
                        check("rec_kind", 32'(cur.is_err), 0);
                        check("rec_eixos", 32'(rec.EIXOS), 32'(cur.eixos));
                        check("rec_peso", 32'(rec.PESO), 32'(cur.peso));
                        check("setup_eixos", 32'(prev_eixos), 32'(cur.eixos));
                        check("setup_peso", 32'(prev_peso), 32'(cur.peso));
                        check("setup_busy", 32'(prev_busy), 1);
                    end
                end else if (rec.READY) begin
                    ready_len++;
                end
                if (!rec.READY && prev_ready && !RESET) begin
                    check("ready_len", ready_len, 6);
                    gap_on  = 1'b1;
                    gap_len = 0;
                end
                if (gap_on) begin
                    if (BUSY) begin
                        gap_len++;
                    end else begin
                        check("gap_len", gap_len, 4);
                        gap_on = 1'b0;
                    end
                end
                if (prev_err)
                    check("err_width", 32'(ERR), 0);
                if (ERR && !prev_err) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_err: got code %0d, expected none", ERR_CODE);
                    end else begin
                        cur = exp_q.pop_front();
                        check("err_kind", 32'(cur.is_err), 1);
                        check("err_code", 32'(ERR_CODE), 32'(cur.code));
                        check("err_eixos_hold", 32'(rec.EIXOS), 32'(cur.eixos));
                        check("err_peso_hold", 32'(rec.PESO), 32'(cur.peso));
                        check("err_ready_low", 32'(rec.READY), 0);
                    end
                end
            end
            prev_ready = rec.READY;
            prev_err   = ERR;
            prev_busy  = BUSY;
            prev_eixos = rec.EIXOS;
            prev_peso  = rec.PESO;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit got;
        RESET       = 1'b1;
        PRESENCE    = 1'b0;
        AXLE_SENSOR = 1'b0;
        WEIGHT_STB  = 1'b0;
        WEIGHT_IN   = 4'd0;

        // Reset held three edges while the inputs toggle.
        repeat (3) begin
            @(posedge CLOCK_50);
            #1;
            PRESENCE    = ~PRESENCE;
            AXLE_SENSOR = ~AXLE_SENSOR;
            WEIGHT_STB  = 1'b1;
            WEIGHT_IN   = 4'd9;
        end
        check("rst_eixos", 32'(rec.EIXOS), 0);
        check("rst_peso", 32'(rec.PESO), 0);
        check("rst_ready", 32'(rec.READY), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_err_code", 32'(ERR_CODE), 0);
        check("rst_busy", 32'(BUSY), 0);
        @(negedge CLOCK_50);
        RESET       = 1'b0;
        PRESENCE    = 1'b0;
        AXLE_SENSOR = 1'b0;
        WEIGHT_STB  = 1'b0;
        WEIGHT_IN   = 4'd0;
        mon_en      = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // Two clean axles, weights 5,7,6.
        push_rec(EIXOS_2, 4'd7);
        vehicle(2, 1'b0, -1, 5, 7, 6);
        repeat (40) @(negedge CLOCK_50);

        // Five bouncy axles, weight 15.
        push_rec(EIXOS_5P, 4'd15);
        vehicle(5, 1'b1, -1, 15, -1, -1);
        repeat (40) @(negedge CLOCK_50);

        // Rejections keep the last record on the bus.
        push_err(ERR_FEW_AXLES, EIXOS_5P, 4'd15);
        vehicle(1, 1'b0, -1, 3, -1, -1);
        repeat (40) @(negedge CLOCK_50);
        push_err(ERR_NO_WEIGHT, EIXOS_5P, 4'd15);
        vehicle(3, 1'b0, -1, -1, -1, -1);
        repeat (40) @(negedge CLOCK_50);
        push_err(2'b11, EIXOS_5P, 4'd15);
        vehicle(0, 1'b0, -1, -1, -1, -1);
        repeat (40) @(negedge CLOCK_50);

        // Short presence dropout between axles 1 and 2 must not split the vehicle.
        push_rec(EIXOS_3, 4'd9);
        vehicle(3, 1'b0, 0, 9, -1, -1);
        repeat (40) @(negedge CLOCK_50);

        // Reset in the third REPORT cycle aborts the record.
        push_rec(EIXOS_2, 4'd4);
        vehicle(2, 1'b0, -1, 4, -1, -1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (rec.READY) got = 1'b1;
        end
        check("abort_ready_seen", 32'(got), 1);
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("abort_ready", 32'(rec.READY), 0);
        check("abort_eixos", 32'(rec.EIXOS), 0);
        check("abort_peso", 32'(rec.PESO), 0);
        check("abort_busy", 32'(BUSY), 0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        push_rec(EIXOS_4, 4'd12);
        vehicle(4, 1'b0, -1, 12, -1, -1);
        repeat (40) @(negedge CLOCK_50);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
